// File: rtl/ysyx_22051013_wbu.sv
// Write-back stage: register-file write port, M-mode CSR file,
// ECALL/MRET handling with registered redirect, and commit record.
module ysyx_22051013_wbu (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [31:0] wb_inst,
  input  logic [63:0] wb_pc,
  input  logic [1:0]  wb_wbctl,
  input  logic [63:0] wb_exu_res,
  input  logic [63:0] wb_wbdata,
  input  logic        wb_rd_ena,
  input  logic [4:0]  wb_rd_addr,
  input  logic [6:0]  wb_csr_ctl,
  input  logic [11:0] wb_csr_addr,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        trap_redirect,
  output logic [63:0] trap_pc,
  output logic        commit_valid,
  output logic [63:0] commit_pc,
  output logic [31:0] commit_inst
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;

  logic [63:0] mstatus_q, mstatus_d;
  logic [63:0] mtvec_q, mtvec_d;
  logic [63:0] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic        redir_q, redir_d;
  logic [63:0] tpc_q, tpc_d;
  logic        cv_q, cv_d;
  logic [63:0] cpc_q, cpc_d;
  logic [31:0] cinst_q, cinst_d;

  logic        ecall, mret, rw, rs, rc;
  logic        csr_wr;
  logic [63:0] csr_rdata;
  logic [63:0] csr_wval;
  logic        unused_ctl;

  assign unused_ctl = ^wb_csr_ctl[6:5];

  // Priority ECALL > MRET > RW > RS > RC
  always_comb begin
    ecall = wb_csr_ctl[3];
    mret  = wb_csr_ctl[4] & ~wb_csr_ctl[3];
    rw    = wb_csr_ctl[0] & ~|wb_csr_ctl[4:3];
    rs    = wb_csr_ctl[1] & ~wb_csr_ctl[0]
          & ~|wb_csr_ctl[4:3];
    rc    = wb_csr_ctl[2] & ~|wb_csr_ctl[1:0]
          & ~|wb_csr_ctl[4:3];
  end

  always_comb begin
    case (wb_csr_addr)
      A_MSTATUS:  csr_rdata = mstatus_q;
      A_MTVEC:    csr_rdata = mtvec_q;
      A_MEPC:     csr_rdata = mepc_q;
      A_MCAUSE:   csr_rdata = mcause_q;
      A_MCYCLE:   csr_rdata = mcycle_q;
      A_MINSTRET: csr_rdata = minstret_q;
      default:    csr_rdata = 64'd0;
    endcase
  end

  always_comb begin
    csr_wr = wb_valid
           & (rw | ((rs | rc) & (|wb_inst[19:15])));
    if (rw)
      csr_wval = wb_exu_res;
    else if (rs)
      csr_wval = csr_rdata | wb_exu_res;
    else
      csr_wval = csr_rdata & ~wb_exu_res;
  end

  always_comb begin
    rf_we = wb_valid & wb_rd_ena
          & (|wb_rd_addr) & (|wb_wbctl);
    rf_waddr = wb_rd_addr;
    case (wb_wbctl)
      2'b01:   rf_wdata = wb_exu_res;
      2'b10:   rf_wdata = wb_wbdata;
      2'b11:   rf_wdata = csr_rdata;
      default: rf_wdata = 64'd0;
    endcase
  end

  always_comb begin
    mstatus_d  = mstatus_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, wb_valid};
    if (csr_wr) begin
      case (wb_csr_addr)
        A_MSTATUS:  mstatus_d  = csr_wval;
        A_MTVEC:    mtvec_d    = csr_wval;
        A_MEPC:     mepc_d     = csr_wval;
        A_MCAUSE:   mcause_d   = csr_wval;
        A_MCYCLE:   mcycle_d   = csr_wval;
        A_MINSTRET: minstret_d = csr_wval;
        default: ;
      endcase
    end
    if (wb_valid & ecall) begin
      mepc_d            = wb_pc;
      mcause_d          = 64'd11;
      mstatus_d[7]      = mstatus_q[3];
      mstatus_d[3]      = 1'b0;
      mstatus_d[12:11]  = 2'b11;
    end else if (wb_valid & mret) begin
      mstatus_d[3]      = mstatus_q[7];
      mstatus_d[7]      = 1'b1;
      mstatus_d[12:11]  = 2'b00;
    end
  end

  always_comb begin
    redir_d = wb_valid & (ecall | mret);
    if (wb_valid & ecall)
      tpc_d = mtvec_q & ~64'h3;
    else if (wb_valid & mret)
      tpc_d = mepc_q;
    else
      tpc_d = tpc_q;
    cv_d    = wb_valid;
    cpc_d   = wb_valid ? wb_pc : cpc_q;
    cinst_d = wb_valid ? wb_inst : cinst_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= 64'd0;
      mtvec_q    <= 64'd0;
      mepc_q     <= 64'd0;
      mcause_q   <= 64'd0;
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
      redir_q    <= 1'b0;
      tpc_q      <= 64'd0;
      cv_q       <= 1'b0;
      cpc_q      <= 64'd0;
      cinst_q    <= 32'd0;
    end else begin
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      redir_q    <= redir_d;
      tpc_q      <= tpc_d;
      cv_q       <= cv_d;
      cpc_q      <= cpc_d;
      cinst_q    <= cinst_d;
    end
  end

  // A pulse queued just before reset must not escape during reset
  assign trap_redirect = redir_q & ~rst;
  assign trap_pc       = tpc_q;
  assign commit_valid  = cv_q & ~rst;
  assign commit_pc     = cpc_q;
  assign commit_inst   = cinst_q;

endmodule

// File: tb/tb_ysyx_22051013_wbu.sv
// Scoreboard bench for the write-back unit: directed vectors,
// commit/redirect expectations checked by an independent monitor.
module tb_ysyx_22051013_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [31:0] wb_inst;
  logic [63:0] wb_pc;
  logic [1:0]  wb_wbctl;
  logic [63:0] wb_exu_res;
  logic [63:0] wb_wbdata;
  logic        wb_rd_ena;
  logic [4:0]  wb_rd_addr;
  logic [6:0]  wb_csr_ctl;
  logic [11:0] wb_csr_addr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        trap_redirect;
  logic [63:0] trap_pc;
  logic        commit_valid;
  logic [63:0] commit_pc;
  logic [31:0] commit_inst;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } cm_t;

  cm_t         cq[$];
  logic [63:0] tq[$];

  ysyx_22051013_wbu dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_inst(wb_inst),
    .wb_pc(wb_pc), .wb_wbctl(wb_wbctl),
    .wb_exu_res(wb_exu_res), .wb_wbdata(wb_wbdata),
    .wb_rd_ena(wb_rd_ena), .wb_rd_addr(wb_rd_addr),
    .wb_csr_ctl(wb_csr_ctl), .wb_csr_addr(wb_csr_addr),
    .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .trap_redirect(trap_redirect), .trap_pc(trap_pc),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a pulse
  always @(negedge clk) begin
    if (commit_valid === 1'b1) begin
      checks++;
      if (cq.size() == 0) begin
        failures++;
        $display("FAIL commit_unexpected got=%h want=none",
                 commit_pc);
      end else begin
        cm_t e;
        e = cq.pop_front();
        if (commit_pc !== e.pc || commit_inst !== e.inst) begin
          failures++;
          $display("FAIL commit got=%h/%h want=%h/%h",
                   commit_pc, commit_inst, e.pc, e.inst);
        end
      end
    end
    if (trap_redirect === 1'b1) begin
      checks++;
      if (tq.size() == 0) begin
        failures++;
        $display("FAIL redirect_unexpected got=%h want=none",
                 trap_pc);
      end else begin
        logic [63:0] t;
        t = tq.pop_front();
        if (trap_pc !== t) begin
          failures++;
          $display("FAIL trap_pc got=%h want=%h", trap_pc, t);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wb_valid    = 1'b0;
    wb_inst     = 32'd0;
    wb_pc       = 64'd0;
    wb_wbctl    = 2'b00;
    wb_exu_res  = 64'd0;
    wb_wbdata   = 64'd0;
    wb_rd_ena   = 1'b0;
    wb_rd_addr  = 5'd0;
    wb_csr_ctl  = 7'd0;
    wb_csr_addr = 12'd0;
  endtask

  task automatic issue(input logic        v,
                       input logic [31:0] inst,
                       input logic [63:0] pc,
                       input logic [1:0]  wbctl,
                       input logic [63:0] exu,
                       input logic [63:0] wbd,
                       input logic [4:0]  rd,
                       input logic [6:0]  ctl,
                       input logic [11:0] addr);
    wb_valid    = v;
    wb_inst     = inst;
    wb_pc       = pc;
    wb_wbctl    = wbctl;
    wb_exu_res  = exu;
    wb_wbdata   = wbd;
    wb_rd_ena   = 1'b1;
    wb_rd_addr  = rd;
    wb_csr_ctl  = ctl;
    wb_csr_addr = addr;
    if (v) cq.push_back('{pc: pc, inst: inst});
    #1;
  endtask

  task automatic rd_csr(input logic [11:0] addr,
                        input logic [63:0] exp,
                        input string name);
    idle();
    wb_wbctl    = 2'b11;
    wb_csr_addr = addr;
    #1;
    chk(name, rf_wdata, exp);
  endtask

  localparam logic [31:0] I_RS1 = 32'h30529073;
  localparam logic [31:0] I_RS0 = 32'h30502373;

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst_commit", {63'd0, commit_valid}, 64'd0);
    chk("rst_redirect", {63'd0, trap_redirect}, 64'd0);
    chk("rst_commit_pc", commit_pc, 64'd0);
    repeat (5) tick();
    rd_csr(12'hB00, 64'd5, "mcycle_5");
    rd_csr(12'hB02, 64'd0, "minstret_0");
    rd_csr(12'h7C0, 64'd0, "unimpl_csr");

    // ALU write, then same with rd=0, then a load
    issue(1, 32'h003100b3, 64'h80000000, 2'b01, 64'h1234,
          64'h0, 5'd3, 7'd0, 12'd0);
    chk("add_we", {63'd0, rf_we}, 64'd1);
    chk("add_waddr", {59'd0, rf_waddr}, 64'd3);
    chk("add_wdata", rf_wdata, 64'h1234);
    tick();
    issue(1, 32'h00310033, 64'h80000004, 2'b01, 64'h1234,
          64'h0, 5'd0, 7'd0, 12'd0);
    chk("rd0_we", {63'd0, rf_we}, 64'd0);
    tick();
    rd_csr(12'hB02, 64'd2, "minstret_2");
    issue(1, 32'h00013383, 64'h80000008, 2'b10, 64'h55,
          64'hCAFE, 5'd7, 7'd0, 12'd0);
    chk("load_wdata", rf_wdata, 64'hCAFE);
    tick();

    // CSRRW / CSRRS(rs1=0) / CSRRC on mtvec
    issue(1, I_RS1, 64'h8000000C, 2'b11, 64'h80000100,
          64'h0, 5'd5, 7'b0000001, 12'h305);
    chk("csrrw_old", rf_wdata, 64'd0);
    chk("csrrw_we", {63'd0, rf_we}, 64'd1);
    tick();
    rd_csr(12'h305, 64'h80000100, "mtvec_rw");
    issue(1, I_RS0, 64'h80000010, 2'b11, 64'hFF,
          64'h0, 5'd6, 7'b0000010, 12'h305);
    chk("csrrs_old", rf_wdata, 64'h80000100);
    tick();
    rd_csr(12'h305, 64'h80000100, "mtvec_rs0");
    issue(0, I_RS1, 64'h0, 2'b11, 64'hDEAD,
          64'h0, 5'd5, 7'b0000001, 12'h305);
    tick();
    rd_csr(12'h305, 64'h80000100, "mtvec_novalid");
    issue(1, I_RS1, 64'h80000014, 2'b00, 64'h100,
          64'h0, 5'd0, 7'b0000100, 12'h305);
    tick();
    rd_csr(12'h305, 64'h80000000, "mtvec_rc");
    issue(1, I_RS1, 64'h80000018, 2'b00, 64'h200,
          64'h0, 5'd0, 7'b0000011, 12'h305);
    tick();
    rd_csr(12'h305, 64'h200, "prio_rw_rs");

    // ECALL then MRET
    issue(1, I_RS1, 64'h8000001C, 2'b00, 64'h80000101,
          64'h0, 5'd0, 7'b0000001, 12'h305);
    tick();
    issue(1, I_RS1, 64'h80000020, 2'b00, 64'h8,
          64'h0, 5'd0, 7'b0000001, 12'h300);
    tick();
    issue(1, 32'h00000073, 64'h80000010, 2'b00, 64'h0,
          64'h0, 5'd0, 7'b0001000, 12'h0);
    tq.push_back(64'h80000100);
    tick();
    chk("ecall_redir", {63'd0, trap_redirect}, 64'd1);
    rd_csr(12'h341, 64'h80000010, "mepc");
    rd_csr(12'h342, 64'd11, "mcause");
    rd_csr(12'h300, 64'h1880, "mstatus_ecall");
    tick();
    chk("redir_1cyc", {63'd0, trap_redirect}, 64'd0);
    issue(1, 32'h30200073, 64'h80000100, 2'b00, 64'h0,
          64'h0, 5'd0, 7'b0010000, 12'h0);
    tq.push_back(64'h80000010);
    tick();
    rd_csr(12'h300, 64'h88, "mstatus_mret");

    // Counter writes beat increments; mcycle wraps
    issue(1, I_RS1, 64'h80000024, 2'b00, 64'h10,
          64'h0, 5'd0, 7'b0000001, 12'hB02);
    tick();
    rd_csr(12'hB02, 64'h10, "minstret_wr");
    issue(1, I_RS1, 64'h80000028, 2'b00, '1,
          64'h0, 5'd0, 7'b0000001, 12'hB00);
    tick();
    rd_csr(12'hB00, '1, "mcycle_max");
    tick();
    rd_csr(12'hB00, 64'd0, "mcycle_wrap");

    // Reset right after an ECALL
    issue(1, 32'h00000073, 64'h80000030, 2'b00, 64'h0,
          64'h0, 5'd0, 7'b0001000, 12'h0);
    tick();
    rst = 1'b1;
    idle();
    #1;
    chk("rst_redir", {63'd0, trap_redirect}, 64'd0);
    chk("rst_cv", {63'd0, commit_valid}, 64'd0);
    cq.delete();
    tq.delete();
    tick();
    rst = 1'b0;
    chk("post_redir", {63'd0, trap_redirect}, 64'd0);
    rd_csr(12'h300, 64'd0, "rst_mstatus");
    rd_csr(12'h305, 64'd0, "rst_mtvec");
    rd_csr(12'h341, 64'd0, "rst_mepc");
    rd_csr(12'h342, 64'd0, "rst_mcause");
    rd_csr(12'hB00, 64'd0, "rst_mcycle");
    rd_csr(12'hB02, 64'd0, "rst_minstret");
    idle();
    tick();
    chk("post_redir2", {63'd0, trap_redirect}, 64'd0);
    chk("post_cv", {63'd0, commit_valid}, 64'd0);
    repeat (3) tick();
    chk("cq_drained", 64'(cq.size()), 64'd0);
    chk("tq_drained", 64'(tq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
